// File: rtl/tri_bus_pkg.sv
// Shared constants for the tri_bus_arbiter slice.
// Provides the arbiter FSM state encoding, the default data width and
// helpers that size the hold counter and the source-index pointer.
package tri_bus_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGrant = 2'd1,
    StTurn  = 2'd2
  } state_e;

  localparam int unsigned DefaultWidth = 4;

  // Counter must be able to hold the value max_hold itself.
  function automatic int unsigned cnt_width(int unsigned max_hold);
    return $clog2(max_hold + 1);
  endfunction

  // Index width, never zero so single-source builds still elaborate.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tri_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Ports:
//   req   - per-source request vector
//   last  - index of the previous owner
//   idx   - winning source index (first set req bit after last, wrapping)
//   valid - at least one request is set
module rr_pick
  import tri_bus_pkg::*;
#(
  parameter int unsigned N_SRC = 4,
  localparam int unsigned IdxW = idx_width(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IdxW-1:0]  last,
  output logic [IdxW-1:0]  idx,
  output logic             valid
);

  logic [IdxW-1:0] cand;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    // Offsets 1..N_SRC visit last+1 first and last itself at the very end.
    for (int unsigned off = 1; off <= N_SRC; off++) begin
      cand = IdxW'((32'(last) + off) % N_SRC);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/tri_bus_arbiter.sv
// tri_bus_arbiter: round-robin owner arbiter feeding a tristate bus buffer.
// Grants one requester at a time, forwards its data, caps tenure at
// MAX_HOLD cycles and forces one all-off cycle between owners so two
// drivers are never enabled together.
// Ports:
//   clk     - clock, rising edge
//   reset   - synchronous, active-high
//   req     - per-source request (level)
//   data_in - packed source data, source i at [i*WIDTH +: WIDTH]
//   gnt     - registered one-hot-or-zero grant
//   tri_en  - registered buffer enable (== |gnt)
//   tri_in  - registered owner data, zero when no owner
module tri_bus_arbiter
  import tri_bus_pkg::*;
#(
  parameter int unsigned N_SRC    = 4,
  parameter int unsigned WIDTH    = DefaultWidth,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_SRC-1:0]         req,
  input  logic [N_SRC*WIDTH-1:0]   data_in,
  output logic [N_SRC-1:0]         gnt,
  output logic                     tri_en,
  output logic [WIDTH-1:0]         tri_in
);

  localparam int unsigned IdxW = idx_width(N_SRC);
  localparam int unsigned CntW = cnt_width(MAX_HOLD);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [N_SRC-1:0]  gnt_q, gnt_d;
  logic              en_q, en_d;
  logic [WIDTH-1:0]  tin_q, tin_d;

  logic [IdxW-1:0]   pick_idx;
  logic              pick_valid;
  logic              grant_d;
  logic [IdxW-1:0]   sel_idx;
  logic [WIDTH-1:0]  sel_data;

  rr_pick #(
    .N_SRC (N_SRC)
  ) u_rr_pick (
    .req   (req),
    .last  (ptr_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Next-state logic. grant_d marks that the next state is GRANT, which is
  // the only state whose registered outputs are non-zero.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = 1'b0;
    sel_idx = ptr_q;
    case (state_q)
      StIdle, StTurn: begin
        if (pick_valid) begin
          state_d = StGrant;
          ptr_d   = pick_idx;
          cnt_d   = CntW'(1);
          grant_d = 1'b1;
          sel_idx = pick_idx;
        end else begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      StGrant: begin
        // Other requests are not looked at until the tenure ends.
        if (!req[ptr_q] || (cnt_q == CntW'(MAX_HOLD))) begin
          state_d = StTurn;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CntW'(1);
          grant_d = 1'b1;
        end
      end
      default: begin
        // Unreachable encoding: fall back to IDLE with outputs off.
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Data mux for the owner (new winner on a granting edge, else current).
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (sel_idx == IdxW'(i)) begin
        sel_data = data_in[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    gnt_d = '0;
    if (grant_d) begin
      gnt_d[sel_idx] = 1'b1;
    end
    en_d  = grant_d;
    tin_d = grant_d ? sel_data : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= IdxW'(N_SRC - 1);
      cnt_q   <= '0;
      gnt_q   <= '0;
      en_q    <= 1'b0;
      tin_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      en_q    <= en_d;
      tin_q   <= tin_d;
    end
  end

  assign gnt    = gnt_q;
  assign tri_en = en_q;
  assign tri_in = tin_q;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Scoreboard bench for tri_bus_arbiter (N_SRC=4, WIDTH=4, MAX_HOLD=4).
// Stimulus drives one cycle at a time and pushes the hand-computed output
// expected after the next rising edge; the monitor pops on the falling edge.
module tb_tri_bus_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] data_in;
  logic [3:0]  gnt;
  logic        tri_en;
  logic [3:0]  tri_in;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  gnt;
    logic        en;
    logic [3:0]  tin;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc;
  int unsigned n_total;
  int unsigned n_pass;
  logic [3:0]  prev_gnt;

  // Source data: src3=C, src2=6, src1=A, src0=3.
  localparam logic [15:0] D = 16'hC6A3;

  tri_bus_arbiter #(
    .N_SRC    (4),
    .WIDTH    (4),
    .MAX_HOLD (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .data_in (data_in),
    .gnt     (gnt),
    .tri_en  (tri_en),
    .tri_in  (tri_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int unsigned at, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s cycle %0d: got %h, required %h", name, at, act, exp);
    end
  endtask

  // Monitor: scoreboard pops plus per-cycle bus invariants.
  always @(negedge clk) begin
    if (cyc > 0) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        check("sb_cycle", cyc, 32'(e.cyc), 32'(cyc));
        check("gnt", cyc, 32'(gnt), 32'(e.gnt));
        check("tri_en", cyc, 32'(tri_en), 32'(e.en));
        check("tri_in", cyc, 32'(tri_in), 32'(e.tin));
      end
      check("onehot0_gnt", cyc, 32'($onehot0(gnt)), 32'd1);
      check("en_eq_or_gnt", cyc, 32'(tri_en), 32'(|gnt));
      check("no_direct_handover", cyc,
            32'((prev_gnt != 4'b0) && (gnt != 4'b0) && (prev_gnt != gnt)), 32'd0);
      prev_gnt = gnt;
    end
  end

  // Apply inputs for one cycle and push the output expected after the edge.
  task automatic step(input logic rst, input logic [3:0] r, input logic [15:0] d,
                      input logic [3:0] eg, input logic [3:0] et);
    exp_t e;
    reset   = rst;
    req     = r;
    data_in = d;
    e.cyc   = cyc + 1;
    e.gnt   = eg;
    e.en    = (eg != 4'b0);
    e.tin   = et;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] owners [5];
    logic [3:0] odata  [5];
    n_total  = 0;
    n_pass   = 0;
    prev_gnt = 4'b0;
    reset    = 1'b1;
    req      = 4'b0;
    data_in  = D;
    @(posedge clk);
    #1;

    // 1. Reset with all requesting: outputs stay zero.
    step(1'b1, 4'b1111, D, 4'b0000, 4'h0);
    step(1'b1, 4'b1111, D, 4'b0000, 4'h0);

    // 2. Lone requester 2: 4 on, 1 off, repeating.
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++) step(1'b0, 4'b0100, D, 4'b0100, 4'h6);
      step(1'b0, 4'b0100, D, 4'b0000, 4'h0);
    end
    step(1'b0, 4'b0000, D, 4'b0000, 4'h0);

    // 3. Two requesters after reset: 0 first, drops after 2 grants, then 1.
    step(1'b1, 4'b0000, D, 4'b0000, 4'h0);
    step(1'b0, 4'b0011, D, 4'b0001, 4'h3);
    step(1'b0, 4'b0011, D, 4'b0001, 4'h3);
    step(1'b0, 4'b0010, D, 4'b0000, 4'h0);
    step(1'b0, 4'b0010, D, 4'b0010, 4'hA);
    step(1'b0, 4'b0010, 16'hC653, 4'b0010, 4'h5);  // data tracked with 1-cycle delay
    step(1'b0, 4'b0010, D, 4'b0010, 4'hA);
    step(1'b0, 4'b0000, D, 4'b0000, 4'h0);         // release ends tenure
    step(1'b0, 4'b0000, D, 4'b0000, 4'h0);

    // 4. All requesting: owners 0,1,2,3,0, 4 cycles each, 1 dead cycle between.
    step(1'b1, 4'b0000, D, 4'b0000, 4'h0);
    owners = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    odata  = '{4'h3, 4'hA, 4'h6, 4'hC, 4'h3};
    for (int o = 0; o < 5; o++) begin
      for (int j = 0; j < 4; j++) step(1'b0, 4'b1111, D, owners[o], odata[o]);
      step(1'b0, 4'b1111, D, 4'b0000, 4'h0);
    end

    // 5. Reset during source 2's tenure; afterwards source 0 wins.
    for (int j = 0; j < 4; j++) step(1'b0, 4'b1111, D, 4'b0010, 4'hA);
    step(1'b0, 4'b1111, D, 4'b0000, 4'h0);
    step(1'b0, 4'b1111, D, 4'b0100, 4'h6);
    step(1'b0, 4'b1111, D, 4'b0100, 4'h6);
    step(1'b1, 4'b1111, D, 4'b0000, 4'h0);
    step(1'b0, 4'b1111, D, 4'b0001, 4'h3);
    step(1'b0, 4'b1111, D, 4'b0001, 4'h3);
    step(1'b0, 4'b0000, D, 4'b0000, 4'h0);
    step(1'b0, 4'b0000, D, 4'b0000, 4'h0);

    // 6. One-cycle pulse on req[3] in IDLE: single grant, TURN, IDLE.
    step(1'b0, 4'b1000, D, 4'b1000, 4'hC);
    step(1'b0, 4'b0000, D, 4'b0000, 4'h0);
    step(1'b0, 4'b0000, D, 4'b0000, 4'h0);
    step(1'b0, 4'b0000, D, 4'b0000, 4'h0);

    @(negedge clk);
    #1;
    check("sb_drained", cyc, 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule
